vga_stream_monitor: RTL and testbench

- Receive-side counterpart of the system's VGA conduit: consumes CLK/HS/VS/BLANK/R/G/B as a display would.
- Measures line and frame timing against expected geometry, flags violations, and produces a per-frame pixel checksum.
- Instantiated on the board-test build, looping the conduit back, so software can confirm the video path without a monitor.

---
 rtl/vga_stream_monitor.sv | 157 +++++++++++++++
 tb/tb_vga_stream_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_monitor.sv
// Receive-side checker for the VGA conduit: measures line/frame timing against the
// expected geometry, tracks lock over consecutive frames and checksums each frame.
module vga_stream_monitor #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_TOTAL  = 800,
    parameter int   V_ACTIVE = 480,
    parameter int   V_TOTAL  = 525,
    parameter logic SYNC_ACT = 1'b0,
    parameter int   CW       = 12
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          vga_CLK,
    input  logic          vga_HS,
    input  logic          vga_VS,
    input  logic          vga_BLANK,
    input  logic [3:0]    vga_R,
    input  logic [3:0]    vga_G,
    input  logic [3:0]    vga_B,
    output logic          locked,
    output logic          frame_valid,
    output logic [15:0]   frame_sum,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] v_total_meas,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {HUNT, ALIGN, CHECK1, LOCKED} state_t;

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_WDOG_C   = CW'(V_TOTAL + 2);

    state_t        state, state_next;
    logic [15:0]   sync1, sync2;
    logic          clk_d3, pix_stb;
    logic          s_clk, s_hs, s_vs, s_blank;
    logic [11:0]   s_rgb;
    logic          hs_prev, vs_prev, hs_edge, vs_edge;
    logic [CW-1:0] h_cnt, act_cnt, v_cnt, act_lines;
    logic [CW-1:0] v_cnt_eff, act_lines_eff;
    logic [15:0]   sum;
    logic          bad_flag, line_bad, frame_bad, wd_fire, err_inc;

    // Every conduit lane shares the same synchronizer so all are aligned to pix_stb.
    assign {s_clk, s_hs, s_vs, s_blank, s_rgb} = sync2;
    assign pix_stb = s_clk & ~clk_d3;
    assign hs_edge = pix_stb && (s_hs == SYNC_ACT) && (hs_prev != SYNC_ACT);
    assign vs_edge = pix_stb && (s_vs == SYNC_ACT) && (vs_prev != SYNC_ACT);
    assign wd_fire = (state != HUNT) && !vs_edge && (v_cnt >= V_WDOG_C);

    // Line-close results folded in first so a coincident VS sees the finished line.
    always_comb begin
        v_cnt_eff     = v_cnt;
        act_lines_eff = act_lines;
        line_bad      = 1'b0;
        if (hs_edge) begin
            line_bad = (h_cnt != H_TOTAL_C) || ((act_cnt != '0) && (act_cnt != H_ACTIVE_C));
            if (v_cnt != CNT_MAX)
                v_cnt_eff = v_cnt + CNT_ONE;
            if ((act_cnt != '0) && (act_lines != CNT_MAX))
                act_lines_eff = act_lines + CNT_ONE;
        end
        frame_bad = bad_flag || line_bad || (v_cnt_eff != V_TOTAL_C) || (act_lines_eff != V_ACTIVE_C);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1        <= '0;
            sync2        <= '0;
            clk_d3       <= 1'b0;
            hs_prev      <= SYNC_ACT;
            vs_prev      <= SYNC_ACT;
            h_cnt        <= '0;
            act_cnt      <= '0;
            v_cnt        <= '0;
            act_lines    <= '0;
            sum          <= '0;
            bad_flag     <= 1'b0;
            frame_valid  <= 1'b0;
            frame_sum    <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            err_count    <= '0;
        end else begin
            sync1       <= {vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_R, vga_G, vga_B};
            sync2       <= sync1;
            clk_d3      <= s_clk;
            frame_valid <= vs_edge && (state != HUNT);
            if (err_inc && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            if (pix_stb) begin
                hs_prev <= s_hs;
                vs_prev <= s_vs;
                if (hs_edge) begin
                    h_total_meas <= h_cnt;
                    h_cnt        <= CNT_ONE;
                    act_cnt      <= '0;
                end else begin
                    if (h_cnt != CNT_MAX)
                        h_cnt <= h_cnt + CNT_ONE;
                    if (s_blank && (act_cnt != CNT_MAX))
                        act_cnt <= act_cnt + CNT_ONE;
                end
                if (vs_edge) begin
                    v_total_meas <= v_cnt_eff;
                    frame_sum    <= sum;
                    sum          <= '0;
                    v_cnt        <= '0;
                    act_lines    <= '0;
                    bad_flag     <= 1'b0;
                end else begin
                    if (s_blank)
                        sum <= sum + {4'b0000, s_rgb};
                    v_cnt     <= v_cnt_eff;
                    act_lines <= act_lines_eff;
                    bad_flag  <= bad_flag | line_bad;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state <= HUNT;
        else
            state <= state_next;
    end

    // The watchdog overrides frame evaluation; HUNT never records an error.
    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        if (wd_fire) begin
            state_next = HUNT;
            err_inc    = 1'b1;
        end else if (vs_edge) begin
            case (state)
                HUNT:    state_next = ALIGN;
                ALIGN:   state_next = frame_bad ? ALIGN : CHECK1;
                CHECK1:  state_next = frame_bad ? ALIGN : LOCKED;
                LOCKED:  state_next = frame_bad ? ALIGN : LOCKED;
                default: state_next = HUNT;
            endcase
            err_inc = frame_bad && (state != HUNT);
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Bench for vga_stream_monitor: drives a small VGA raster at clk/4 and compares each
// frame_valid pulse against a frame-level model queued as the frames are sent.
module tb_vga_stream_monitor;

    localparam int H_ACT = 8;
    localparam int H_TOT = 12;
    localparam int V_ACT = 4;
    localparam int V_TOT = 6;
    localparam int CW    = 12;

    typedef enum int {M_HUNT, M_ALIGN, M_CHECK1, M_LOCKED} mstate_t;

    typedef struct {
        logic [15:0]   sum;
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic [7:0]    err;
        logic          lk;
    } exp_t;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          vga_CLK, vga_HS, vga_VS, vga_BLANK;
    logic [3:0]    vga_R, vga_G, vga_B;
    logic          locked, frame_valid;
    logic [15:0]   frame_sum;
    logic [CW-1:0] h_total_meas, v_total_meas;
    logic [7:0]    err_count;

    exp_t    exp_q[$];
    exp_t    mon_e;
    int      checks = 0;
    int      errors = 0;
    mstate_t m_state;
    int      m_err;
    int      prev_v_len;

    vga_stream_monitor #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
        .SYNC_ACT(1'b0), .CW(CW)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .vga_CLK(vga_CLK), .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
        .locked(locked), .frame_valid(frame_valid), .frame_sum(frame_sum),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .err_count(err_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_locked"}, 32'(locked), 32'd0);
        check_output({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check_output({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
        check_output({tag, "_h_total"}, 32'(h_total_meas), 32'd0);
        check_output({tag, "_v_total"}, 32'(v_total_meas), 32'd0);
        check_output({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    // One pixel is four clk_clk cycles; data changes with the falling pixel clock.
    task automatic drive_pixel(input logic hs, input logic vs, input logic blank, input logic [11:0] rgb);
        @(negedge clk_clk);
        vga_CLK   = 1'b0;
        vga_HS    = hs;
        vga_VS    = vs;
        vga_BLANK = blank;
        {vga_R, vga_G, vga_B} = rgb;
        repeat (2) @(negedge clk_clk);
        vga_CLK = 1'b1;
        @(negedge clk_clk);
    endtask

    task automatic send_line(input int len, input bit vsync, input bit active, input logic [11:0] rgb);
        for (int i = 0; i < len; i++) begin
            logic px;
            px = active && (i >= 3) && (i <= 10);
            drive_pixel((i < 2) ? 1'b0 : 1'b1, vsync ? 1'b0 : 1'b1, px, px ? rgb : 12'h000);
        end
    endtask

    // Sends one frame ending in a VS line and queues what the closing pulse should report.
    task automatic apply_stimulus(input int n_act, input int n_lines, input int line_len,
                                  input int short_idx, input logic [11:0] rgb);
        bit          bad;
        int          len;
        exp_t        e;
        logic [15:0] fsum;
        bad  = (prev_v_len != H_TOT) || (n_lines != V_TOT) || (n_act != V_ACT);
        fsum = 16'(n_act * H_ACT * int'(rgb));
        len  = line_len;
        for (int l = 0; l < n_lines - 1; l++) begin
            len = (l == short_idx) ? H_TOT - 1 : line_len;
            if (len != H_TOT)
                bad = 1'b1;
            send_line(len, 1'b0, l < n_act, rgb);
        end
        if (m_state == M_HUNT) begin
            m_state = M_ALIGN;
        end else begin
            if (bad) begin
                m_state = M_ALIGN;
                if (m_err < 255)
                    m_err++;
            end else if (m_state == M_ALIGN) begin
                m_state = M_CHECK1;
            end else begin
                m_state = M_LOCKED;
            end
            e.sum = fsum;
            e.h   = CW'(len);
            e.v   = CW'(n_lines);
            e.err = 8'(m_err);
            e.lk  = (m_state == M_LOCKED);
            exp_q.push_back(e);
        end
        send_line(line_len, 1'b1, 1'b0, rgb);
        prev_v_len = line_len;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_clk);
        reset_reset = 1'b1;
        repeat (cycles) @(negedge clk_clk);
        reset_reset = 1'b0;
        m_state = M_HUNT;
        m_err   = 0;
    endtask

    always @(negedge clk_clk) begin
        if (frame_valid === 1'b1) begin
            check_output("fv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_output("sb_frame_sum", 32'(frame_sum), 32'(mon_e.sum));
                check_output("sb_h_total", 32'(h_total_meas), 32'(mon_e.h));
                check_output("sb_v_total", 32'(v_total_meas), 32'(mon_e.v));
                check_output("sb_err_count", 32'(err_count), 32'(mon_e.err));
                check_output("sb_locked", 32'(locked), 32'(mon_e.lk));
            end
        end
    end

    initial begin
        reset_reset = 1'b1;
        vga_CLK     = 1'b0;
        vga_HS      = 1'b1;
        vga_VS      = 1'b1;
        vga_BLANK   = 1'b0;
        {vga_R, vga_G, vga_B} = 12'h000;
        m_state     = M_HUNT;
        m_err       = 0;
        prev_v_len  = H_TOT;
        repeat (4) @(negedge clk_clk);
        reset_reset = 1'b0;
        check_all_zero("reset");

        $display("[TB] nominal frames");
        apply_stimulus(4, 6, 12, -1, 12'h001);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("nom_f2_locked", 32'(locked), 32'd0);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("nom_f3_locked", 32'(locked), 32'd1);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("nom_frame_sum", 32'(frame_sum), 32'h0020);
        check_output("nom_h_total", 32'(h_total_meas), 32'd12);
        check_output("nom_v_total", 32'(v_total_meas), 32'd6);
        check_output("nom_err_count", 32'(err_count), 32'd0);

        $display("[TB] short line");
        apply_stimulus(4, 6, 12, 0, 12'h001);
        check_output("short_locked", 32'(locked), 32'd0);
        check_output("short_err_count", 32'(err_count), 32'd1);
        check_output("short_h_total", 32'(h_total_meas), 32'd12);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("short_relock", 32'(locked), 32'd1);

        $display("[TB] active line mismatch");
        apply_stimulus(5, 6, 12, -1, 12'h001);
        check_output("act_err_count", 32'(err_count), 32'd2);
        check_output("act_locked", 32'(locked), 32'd0);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("act_relock", 32'(locked), 32'd1);

        $display("[TB] missing vsync");
        repeat (7) send_line(12, 1'b0, 1'b0, 12'h000);
        check_output("wd_before_locked", 32'(locked), 32'd1);
        check_output("wd_before_err", 32'(err_count), 32'd2);
        send_line(12, 1'b0, 1'b0, 12'h000);
        m_state = M_HUNT;
        m_err++;
        check_output("wd_locked", 32'(locked), 32'd0);
        check_output("wd_err_count", 32'(err_count), 32'd3);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("wd_resume_locked", 32'(locked), 32'd0);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("wd_relock", 32'(locked), 32'd1);

        $display("[TB] mid-frame reset");
        send_line(12, 1'b0, 1'b1, 12'h001);
        send_line(12, 1'b0, 1'b1, 12'h001);
        do_reset(1);
        check_all_zero("midreset");
        apply_stimulus(4, 6, 12, -1, 12'h001);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("midreset_f1_locked", 32'(locked), 32'd0);
        apply_stimulus(4, 6, 12, -1, 12'h001);
        check_output("midreset_locked", 32'(locked), 32'd1);
        check_output("midreset_err", 32'(err_count), 32'd0);

        $display("[TB] saturation and checksum wrap");
        repeat (300) apply_stimulus(0, 2, 4, -1, 12'h000);
        check_output("sat_err_count", 32'(err_count), 32'd255);
        apply_stimulus(4, 6, 12, -1, 12'hFFF);
        check_output("wrap_frame_sum", 32'(frame_sum), 32'hFFE0);
        apply_stimulus(4, 6, 12, -1, 12'hFFF);
        apply_stimulus(4, 6, 12, -1, 12'hFFF);
        check_output("wrap_locked", 32'(locked), 32'd1);
        check_output("wrap_err_hold", 32'(err_count), 32'd255);

        repeat (20) @(negedge clk_clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
